// File: rtl/mem_mpu_regions.sv
// Memory protection unit between the CPU memory port and on-chip RAM: data accesses
// are checked against a table of code/data windows; denied accesses fault and raise irq.
module mem_mpu_regions #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_WIDTH  = 22,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      mpu_en,
  input  logic                      cpu_valid,
  input  logic                      cpu_instr,
  input  logic [31:0]               cpu_pc,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cpu_wstrb,
  output logic                      cpu_ready,
  output logic [DATA_WIDTH-1:0]     cpu_rdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wen,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      cfg_we,
  input  logic [3:0]                cfg_idx,
  input  logic [2:0]                cfg_field,
  input  logic [31:0]               cfg_wdata,
  output logic                      irq,
  output logic                      fault_valid,
  input  logic                      fault_clr,
  output logic [ADDR_WIDTH-1:0]     fault_addr,
  output logic [31:0]               fault_pc,
  output logic                      fault_write,
  output logic [2:0]                dbg_state
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  // Handshake: the CPU holds cpu_valid until a single-cycle cpu_ready pulse; a request
  // is accepted only in IDLE, so a held valid during the transaction is ignored.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [31:0]            pc_lo_q [NUM_REGIONS];
  logic [31:0]            pc_hi_q [NUM_REGIONS];
  logic [31:0]            d_lo_q  [NUM_REGIONS];
  logic [31:0]            d_hi_q  [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] en_q, r_q, w_q;

  logic [31:0]            pc_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [SW-1:0]          wstrb_q;
  logic                   instr_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic                   fault_valid_q;
  logic [ADDR_WIDTH-1:0]  fault_addr_q;
  logic [31:0]            fault_pc_q;
  logic                   fault_write_q;

  logic [31:0]            addr_ext;
  logic                   hit;
  logic                   grant;
  logic                   last_access;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        pc_lo_q[i] <= '0;
        pc_hi_q[i] <= '0;
        d_lo_q[i]  <= '0;
        d_hi_q[i]  <= '0;
      end
      en_q <= '0;
      r_q  <= '0;
      w_q  <= '0;
    end else if (cfg_we) begin
      // Indices at or beyond NUM_REGIONS never match, so those writes are dropped.
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (int'(cfg_idx) == i) begin
          case (cfg_field)
            3'd0: pc_lo_q[i] <= cfg_wdata;
            3'd1: pc_hi_q[i] <= cfg_wdata;
            3'd2: d_lo_q[i]  <= cfg_wdata;
            3'd3: d_hi_q[i]  <= cfg_wdata;
            3'd4: begin
              en_q[i] <= cfg_wdata[2];
              w_q[i]  <= cfg_wdata[1];
              r_q[i]  <= cfg_wdata[0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign addr_ext = 32'(addr_q);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (en_q[i] &&
          pc_q >= pc_lo_q[i] && pc_q <= pc_hi_q[i] &&
          addr_ext >= d_lo_q[i] && addr_ext <= d_hi_q[i] &&
          ((wstrb_q == '0) ? r_q[i] : w_q[i]))
        hit = 1'b1;
    end
  end

  assign grant       = instr_q | ~mpu_en | hit;
  assign last_access = (cnt_q == CW'(MEM_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    irq       = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE:  if (cpu_valid) state_d = S_CHECK;
      S_CHECK: state_d = grant ? S_ACCESS : S_FAULT;
      S_ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) mem_wen = wstrb_q;
        if (last_access) state_d = S_RESP;
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = rdata_q;
        state_d   = S_IDLE;
      end
      S_FAULT: begin
        cpu_ready = 1'b1;
        irq       = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      instr_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (cpu_valid) begin
            pc_q    <= cpu_pc;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wstrb_q <= cpu_wstrb;
            instr_q <= cpu_instr;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (last_access) rdata_q <= (wstrb_q == '0) ? mem_rdata : '0;
        end
        default: ;
      endcase
    end
  end

  // A fault arriving with fault_clr replaces the capture rather than being lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_pc_q    <= '0;
      fault_write_q <= 1'b0;
    end else if (state_q == S_FAULT && (!fault_valid_q || fault_clr)) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= addr_q;
      fault_pc_q    <= pc_q;
      fault_write_q <= (wstrb_q != '0);
    end else if (fault_clr) begin
      fault_valid_q <= 1'b0;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_pc    = fault_pc_q;
  assign fault_write = fault_write_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_mpu_regions.sv
// Directed bench for mem_mpu_regions: requests push expected {irq, rdata} into a queue,
// a negedge monitor pops and compares on every cpu_ready pulse.
module tb_mem_mpu_regions;

  localparam int AW = 22;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int W  = DW + 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          mpu_en = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_instr = 1'b0;
  logic [31:0]   cpu_pc = '0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [SW-1:0] cpu_wstrb = '0;
  logic          cpu_ready;
  logic [DW-1:0] cpu_rdata;
  logic [SW-1:0] mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          cfg_we = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [2:0]    cfg_field = '0;
  logic [31:0]   cfg_wdata = '0;
  logic          irq;
  logic          fault_valid;
  logic          fault_clr = 1'b0;
  logic [AW-1:0] fault_addr;
  logic [31:0]   fault_pc;
  logic          fault_write;
  logic [2:0]    dbg_state;

  logic [W-1:0]  exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            wen_total = 0;
  logic [SW-1:0] wen_last = '0;

  mem_mpu_regions #(.NUM_REGIONS(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut (
    .clk(clk), .resetn(resetn), .mpu_en(mpu_en),
    .cpu_valid(cpu_valid), .cpu_instr(cpu_instr), .cpu_pc(cpu_pc), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_wdata(cfg_wdata),
    .irq(irq), .fault_valid(fault_valid), .fault_clr(fault_clr), .fault_addr(fault_addr),
    .fault_pc(fault_pc), .fault_write(fault_write), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // RAM stand-in: a read returns a word derived from the address, so expectations are easy to write
  assign mem_rdata = 32'hDEAD0000 | {10'b0, mem_addr};

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mem_wen != '0) begin
      wen_total = wen_total + 1;
      wen_last  = mem_wen;
    end
    if (irq && !cpu_ready) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL irq_without_ready: irq=%b ready=%b", irq, cpu_ready);
    end
    if (cpu_ready) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_ready: got irq=%b rdata=%h with nothing expected", irq, cpu_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({irq, cpu_rdata} !== e) begin
          bad = bad + 1;
          $display("FAIL response: got irq=%b rdata=%h expected irq=%b rdata=%h",
                   irq, cpu_rdata, e[W-1], e[DW-1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [2:0] field, input logic [31:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_field = field; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic set_region(input logic [3:0] idx, input logic [31:0] pl, input logic [31:0] ph,
                            input logic [31:0] dl, input logic [31:0] dh, input logic [2:0] ewr);
    cfg(idx, 3'd0, pl);
    cfg(idx, 3'd1, ph);
    cfg(idx, 3'd2, dl);
    cfg(idx, 3'd3, dh);
    cfg(idx, 3'd4, {29'b0, ewr});
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  // Drives one request, waits (bounded) for ready, checks latency and mem_wen pulse count.
  task automatic do_req(input string name, input logic instr, input logic [31:0] pc,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [SW-1:0] wstrb, input logic exp_irq,
                        input logic [DW-1:0] exp_rdata, input int exp_lat, input int exp_wen,
                        input logic clr_on_resp, input logic drop_early);
    int n;
    int wen0;
    bit done;
    exp_q.push_back({exp_irq, exp_rdata});
    @(negedge clk);
    wen0 = wen_total;
    cpu_valid = 1'b1; cpu_instr = instr; cpu_pc = pc; cpu_addr = addr;
    cpu_wdata = wdata; cpu_wstrb = wstrb;
    n = 0;
    done = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (drop_early && n == 1) cpu_valid = 1'b0;
      if (cpu_ready) done = 1;
    end
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_wstrb = '0;
    if (!done) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL %s_timeout: no ready within %0d cycles", name, n);
    end else begin
      chk({name, "_latency"}, n, exp_lat);
    end
    fault_clr = clr_on_resp;
    @(negedge clk);
    fault_clr = 1'b0;
    chk({name, "_wen_cycles"}, wen_total - wen0, exp_wen);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cpu_ready}, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    chk("rst_fault_valid", {31'b0, fault_valid}, 0);
    chk("rst_mem_wen", {28'b0, mem_wen}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_state", {29'b0, dbg_state}, 0);
    resetn = 1'b1;

    // granted write and read in region 0
    set_region(4'd0, 32'h100, 32'h1FF, 32'h4000, 32'h40FF, 3'b111);
    do_req("wr_grant", 0, 32'h120, 22'h4010, 32'hA5A5A5A5, 4'hF, 0, 32'h0, 3, 1, 0, 0);
    chk("wr_grant_wen_val", {28'b0, wen_last}, 32'hF);
    chk("wr_grant_no_fault", {31'b0, fault_valid}, 0);
    do_req("rd_grant_drop", 0, 32'h120, 22'h4010, 32'h0, 4'h0, 0, 32'hDEAD4010, 3, 0, 0, 1);

    // read outside the data window
    do_req("rd_out", 0, 32'h120, 22'h4100, 32'h0, 4'h0, 1, 32'h0, 2, 0, 0, 0);
    chk("rd_out_fv", {31'b0, fault_valid}, 1);
    chk("rd_out_faddr", {10'b0, fault_addr}, 32'h4100);
    chk("rd_out_fpc", fault_pc, 32'h120);
    chk("rd_out_fwrite", {31'b0, fault_write}, 0);
    pulse_clr();
    chk("clr1_fv", {31'b0, fault_valid}, 0);

    // read-only region: write faults, first fault wins, clear-with-fault recaptures
    cfg(4'd0, 3'd4, 32'h5);
    do_req("wr_ro", 0, 32'h120, 22'h4000, 32'h1234, 4'h3, 1, 32'h0, 2, 0, 0, 0);
    chk("wr_ro_fwrite", {31'b0, fault_write}, 1);
    chk("wr_ro_faddr", {10'b0, fault_addr}, 32'h4000);
    do_req("rd_ro", 0, 32'h120, 22'h4004, 32'h0, 4'h0, 0, 32'hDEAD4004, 3, 0, 0, 0);
    do_req("wr_ro2", 0, 32'h1FF, 22'h40F0, 32'h1, 4'h1, 1, 32'h0, 2, 0, 0, 0);
    chk("keep_faddr", {10'b0, fault_addr}, 32'h4000);
    chk("keep_fpc", fault_pc, 32'h120);
    do_req("clr_with_fault", 0, 32'h150, 22'h4200, 32'h0, 4'h0, 1, 32'h0, 2, 0, 1, 0);
    chk("clrf_fv", {31'b0, fault_valid}, 1);
    chk("clrf_faddr", {10'b0, fault_addr}, 32'h4200);
    chk("clrf_fwrite", {31'b0, fault_write}, 0);
    pulse_clr();
    chk("clr2_fv", {31'b0, fault_valid}, 0);

    // empty table: fetch passes, data faults, mpu off grants everything
    cfg(4'd0, 3'd4, 32'h0);
    do_req("fetch_empty", 1, 32'h0, 22'h0, 32'h0, 4'h0, 0, 32'hDEAD0000, 3, 0, 0, 0);
    do_req("data_empty", 0, 32'h120, 22'h0, 32'h0, 4'h0, 1, 32'h0, 2, 0, 0, 0);
    mpu_en = 1'b0;
    do_req("mpu_off_wr", 0, 32'h0, 22'h10, 32'h55, 4'h1, 0, 32'h0, 3, 1, 0, 0);
    mpu_en = 1'b1;

    // window boundaries and overlapping regions
    set_region(4'd2, 32'h300, 32'h3FF, 32'h6000, 32'h60FF, 3'b111);
    set_region(4'd3, 32'h300, 32'h3FF, 32'h6000, 32'h60FF, 3'b101);
    do_req("d_hi", 0, 32'h300, 22'h60FF, 32'h0, 4'h0, 0, 32'hDEAD60FF, 3, 0, 0, 0);
    do_req("d_hi_p1", 0, 32'h300, 22'h6100, 32'h0, 4'h0, 1, 32'h0, 2, 0, 0, 0);
    do_req("pc_hi", 0, 32'h3FF, 22'h6000, 32'h0, 4'h0, 0, 32'hDEAD6000, 3, 0, 0, 0);
    do_req("pc_lo_m1", 0, 32'h2FF, 22'h6000, 32'h0, 4'h0, 1, 32'h0, 2, 0, 0, 0);
    do_req("overlap_wr", 0, 32'h300, 22'h6080, 32'hCAFE, 4'hC, 0, 32'h0, 3, 1, 0, 0);
    chk("overlap_wen_val", {28'b0, wen_last}, 32'hC);
    cfg(4'd2, 3'd4, 32'h0);
    do_req("ro_only_wr", 0, 32'h300, 22'h6080, 32'hCAFE, 4'hC, 1, 32'h0, 2, 0, 0, 0);
    do_req("ro_only_rd", 0, 32'h300, 22'h6080, 32'h0, 4'h0, 0, 32'hDEAD6080, 3, 0, 0, 0);
    set_region(4'd8, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 3'b111);
    do_req("idx_oob", 0, 32'h300, 22'h6080, 32'hCAFE, 4'hC, 1, 32'h0, 2, 0, 0, 0);

    // reset during ACCESS aborts the transaction and clears the table
    @(negedge clk);
    cpu_valid = 1'b1; cpu_pc = 32'h300; cpu_addr = 22'h6000; cpu_wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_access_state", {29'b0, dbg_state}, 2);
    chk("mid_access_addr", {10'b0, mem_addr}, 32'h6000);
    resetn = 1'b0;
    cpu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_abort_ready", {31'b0, cpu_ready}, 0);
    end
    chk("rst_abort_addr", {10'b0, mem_addr}, 0);
    chk("rst_abort_fv", {31'b0, fault_valid}, 0);
    resetn = 1'b1;
    do_req("after_rst", 0, 32'h300, 22'h6000, 32'h0, 4'h0, 1, 32'h0, 2, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
